// File: rtl/risc_spm_pkg.sv
// rtl/risc_spm_pkg.sv - shared opcode map and data width for the RISC_SPM datapath
//
// Purpose: one place for the ALU opcode encodings and the default data width,
//          imported by the ALU and the controller so both agree on CNTL.
// Ports:   none (package).
package risc_spm_pkg;

  localparam int RISC_WIDTH = 8;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_SHL  = 3'b111;

endpackage

// File: rtl/risc_spm_alu_comb.sv
// rtl/risc_spm_alu_comb.sv - combinational ALU result and status flags
//
// Purpose: computes r = f(A, B, CNTL) plus zero/ovr/neg with no state.
// Ports:
//   A, B  in   WIDTH  operands (two's complement for ADD/SUB/SHL overflow)
//   CNTL  in   3      operation select (OP_* in risc_spm_pkg)
//   r     out  WIDTH  result, carry-out discarded
//   zero  out  1      r == 0
//   ovr   out  1      signed overflow for ADD/SUB/SHL, 0 otherwise
//   neg   out  1      r[WIDTH-1]
module risc_spm_alu_comb
  import risc_spm_pkg::*;
#(
  parameter int WIDTH = RISC_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CNTL,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovr,
  output logic             neg
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    r   = A;
    ovr = 1'b0;
    case (CNTL)
      OP_PASS: r = A;
      OP_ADD: begin
        r   = A + B;
        // Same-sign operands producing a different-sign sum.
        ovr = (A[MSB] == B[MSB]) && (r[MSB] != A[MSB]);
      end
      OP_SUB: begin
        r   = A - B;
        // Opposite-sign operands where the difference loses A's sign.
        ovr = (A[MSB] != B[MSB]) && (r[MSB] != A[MSB]);
      end
      OP_AND:  r = A & B;
      OP_OR:   r = A | B;
      OP_XOR:  r = A ^ B;
      OP_NOT:  r = ~A;
      OP_SHL: begin
        r   = {A[MSB-1:0], 1'b0};
        // Doubling overflows exactly when the sign bit changes.
        ovr = A[MSB] ^ A[MSB-1];
      end
      default: begin
        r   = A;
        ovr = 1'b0;
      end
    endcase
  end

  assign zero = (r == '0);
  assign neg  = r[MSB];

endmodule

// File: rtl/risc_spm_alu.sv
// rtl/risc_spm_alu.sv - registered 8-bit ALU for the RISC_SPM datapath
//
// Purpose: registers the combinational ALU result and flags (one clock latency).
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      synchronous active-high reset, priority over the operation
//   A, B  in   WIDTH  operands
//   CNTL  in   3      operation select
//   Y     out  WIDTH  registered result (register-file write bus)
//   zero  out  1      registered Y == 0
//   ovr   out  1      registered signed overflow
//   neg   out  1      registered Y[WIDTH-1]
module risc_spm_alu
  import risc_spm_pkg::*;
#(
  parameter int WIDTH = RISC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       CNTL,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             ovr,
  output logic             neg
);

  logic [WIDTH-1:0] r_comb;
  logic             zero_comb;
  logic             ovr_comb;
  logic             neg_comb;

  risc_spm_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .A    (A),
    .B    (B),
    .CNTL (CNTL),
    .r    (r_comb),
    .zero (zero_comb),
    .ovr  (ovr_comb),
    .neg  (neg_comb)
  );

  // Reset state is self-consistent: Y = 0 so zero is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y    <= '0;
      zero <= 1'b1;
      ovr  <= 1'b0;
      neg  <= 1'b0;
    end else begin
      Y    <= r_comb;
      zero <= zero_comb;
      ovr  <= ovr_comb;
      neg  <= neg_comb;
    end
  end

endmodule

// File: tb/tb_risc_spm_alu.sv
// tb/tb_risc_spm_alu.sv - self-checking bench for risc_spm_alu
module tb_risc_spm_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] CNTL;
  logic [7:0] Y;
  logic       zero;
  logic       ovr;
  logic       neg;

  int checks = 0;
  int errors = 0;

  // Expected outputs packed as {Y, zero, ovr, neg}.
  logic [10:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] cntl;
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       n;
  } vec_t;

  vec_t vecs[15];

  risc_spm_alu dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .CNTL (CNTL),
    .Y    (Y),
    .zero (zero),
    .ovr  (ovr),
    .neg  (neg)
  );

  always #5 clk = ~clk;

  // Reference model using integer signed arithmetic for overflow detection.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] c);
    int sa, sb, s;
    logic [7:0] y;
    logic o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    o  = 1'b0;
    case (c)
      3'd0: y = a;
      3'd1: begin s = sa + sb; y = 8'(a + b); o = (s > 127) || (s < -128); end
      3'd2: begin s = sa - sb; y = 8'(a - b); o = (s > 127) || (s < -128); end
      3'd3: y = a & b;
      3'd4: y = a | b;
      3'd5: y = a ^ b;
      3'd6: y = ~a;
      default: begin s = sa * 2; y = 8'(a * 2); o = (s > 127) || (s < -128); end
    endcase
    return {y, (y == 8'h00), o, y[7]};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got Y=%h z=%b o=%b n=%b, required Y=%h z=%b o=%b n=%b",
               name, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input string name, input logic r, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] c, input logic [10:0] exp);
    logic [10:0] e;
    rst  = r;
    A    = a;
    B    = b;
    CNTL = c;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      check(name, {Y, zero, ovr, neg}, e);
    end
  endtask

  initial begin
    logic [7:0] sa, sbv;
    logic [2:0] sc;
    logic [10:0] last;

    vecs[0]  = '{8'h7F, 8'h01, 3'd1, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h80, 8'h01, 3'd2, 8'h7F, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{8'h04, 8'h04, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'hF0, 8'h3C, 3'd3, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'h3C, 3'd4, 8'hFC, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'hF0, 8'h3C, 3'd5, 8'hCC, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'hF0, 8'h3C, 3'd6, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h40, 8'h00, 3'd7, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'hC0, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h00, 8'h5A, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h9A, 8'h00, 3'd0, 8'h9A, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'h80, 8'h00, 3'd7, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{8'h00, 8'h01, 3'd2, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h80, 8'h80, 3'd1, 8'h00, 1'b1, 1'b1, 1'b0};

    // Reset held two cycles with a live ADD on the inputs, then released.
    step("reset_c0", 1'b1, 8'h55, 8'hAA, 3'd1, {8'h00, 1'b1, 1'b0, 1'b0});
    step("reset_c1", 1'b1, 8'h55, 8'hAA, 3'd1, {8'h00, 1'b1, 1'b0, 1'b0});
    step("reset_release", 1'b0, 8'h55, 8'hAA, 3'd1, {8'hFF, 1'b0, 1'b0, 1'b1});

    foreach (vecs[i])
      step($sformatf("vec%0d", i), 1'b0, vecs[i].a, vecs[i].b, vecs[i].cntl,
           {vecs[i].y, vecs[i].z, vecs[i].o, vecs[i].n});

    // Outputs must hold between edges while inputs change.
    step("hold_setup", 1'b0, 8'h7F, 8'h01, 3'd1, {8'h80, 1'b0, 1'b1, 1'b1});
    last = {8'h80, 1'b0, 1'b1, 1'b1};
    A = 8'h00; B = 8'h00; CNTL = 3'd0;
    #2;
    check("hold_between_edges", {Y, zero, ovr, neg}, last);

    // Reset mid-stream overrides an overflowing ADD, then operation resumes.
    step("rst_priority", 1'b1, 8'h7F, 8'h01, 3'd1, {8'h00, 1'b1, 1'b0, 1'b0});
    step("rst_resume", 1'b0, 8'h7F, 8'h01, 3'd1, {8'h80, 1'b0, 1'b1, 1'b1});

    // Sweep: A steps by 4 each cycle, B by 4 every 64 cycles, CNTL cycles 1..5.
    sa = 8'h00; sbv = 8'h00; sc = 3'd1;
    for (int n = 0; n < 4096; n++) begin
      step("sweep", 1'b0, sa, sbv, sc, model(sa, sbv, sc));
      sa = sa + 8'd4;
      if ((n % 64) == 63) sbv = sbv + 8'd4;
      sc = (sc == 3'd5) ? 3'd1 : sc + 3'd1;
    end

    // Short sweep over NOT and SHL, which the main sweep never selects.
    for (int n = 0; n < 64; n++) begin
      sa = 8'(n * 4 + 1);
      step("sweep_not_shl", 1'b0, sa, 8'h00, (n % 2 == 0) ? 3'd6 : 3'd7,
           model(sa, 8'h00, (n % 2 == 0) ? 3'd6 : 3'd7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
